// File: rtl/ysyx_23060201_idu_stage_if.sv
// rtl/ysyx_23060201_idu_stage_if.sv - handshake and decoded-field bundle for the decode stage
interface ysyx_23060201_idu_stage_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [6:0]      out_op;
    logic [4:0]      out_rd;
    logic [2:0]      out_func3;
    logic [6:0]      out_func7;
    logic [4:0]      out_raddr1;
    logic [4:0]      out_raddr2;
    logic [1:0]      out_gpr_ren;
    logic            out_illegal;
    logic            out_ebreak;
    logic [CW-1:0]   count;

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_imm, out_op, out_rd, out_func3, out_func7,
               out_raddr1, out_raddr2, out_gpr_ren, out_illegal, out_ebreak, count
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_imm, out_op, out_rd, out_func3, out_func7,
               out_raddr1, out_raddr2, out_gpr_ren, out_illegal, out_ebreak, count
    );
endinterface

// File: rtl/ysyx_23060201_idu_stage.sv
// rtl/ysyx_23060201_idu_stage.sv - instruction queue feeding a registered RV decode stage
module ysyx_23060201_idu_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_23060201_idu_stage_if.slave  bus
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_IL  = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_U   = 7'b0110111;
    localparam logic [6:0] OP_UPC = 7'b0010111;
    localparam logic [6:0] OP_J   = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_SYS = 7'b1110011;
    localparam logic [6:0] OP_IW  = 7'b0011011;
    localparam logic [6:0] OP_RW  = 7'b0111011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } entry_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [6:0]      op;
        logic [4:0]      rd;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [4:0]      raddr1;
        logic [4:0]      raddr2;
        logic [1:0]      gpr_ren;
        logic            illegal;
        logic            ebreak;
    } dec_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          out_valid_q, out_valid_d;
    dec_t          out_q, out_d, dec;

    logic          in_ready, push, pop;
    logic [31:0]   inst, imm32;
    logic [31:0]   i_imm, s_imm, b_imm, u_imm, j_imm;

    // in_ready depends only on registered occupancy, never on out_ready
    assign in_ready = (count_q < FULL);
    assign push     = bus.in_valid && in_ready;
    assign pop      = (count_q != '0) && (!out_valid_q || bus.out_ready);

    assign inst  = mem_q[rd_ptr_q].inst;
    assign i_imm = {{20{inst[31]}}, inst[31:20]};
    assign s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign b_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign u_imm = {inst[31:12], 12'h000};
    assign j_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        dec         = '0;
        imm32       = '0;
        dec.pc      = mem_q[rd_ptr_q].pc;
        dec.op      = inst[6:0];
        dec.rd      = inst[11:7];
        dec.func3   = inst[14:12];
        dec.func7   = inst[31:25];
        dec.raddr1  = inst[19:15];
        dec.raddr2  = inst[24:20];
        case (inst[6:0])
            OP_R:              dec.gpr_ren = 2'b11;
            OP_I, OP_IL, OP_JR: begin imm32 = i_imm; dec.gpr_ren = 2'b01; end
            OP_SYS:            imm32 = i_imm;
            OP_S:              begin imm32 = s_imm; dec.gpr_ren = 2'b11; end
            OP_B:              begin imm32 = b_imm; dec.gpr_ren = 2'b11; end
            OP_U, OP_UPC:      begin imm32 = u_imm; dec.func3 = 3'b000; end
            OP_J:              imm32 = j_imm;
            OP_IW: begin
                if (XLEN == 64) begin imm32 = i_imm; dec.gpr_ren = 2'b01; end
                else            dec.illegal = 1'b1;
            end
            OP_RW: begin
                if (XLEN == 64) dec.gpr_ren = 2'b11;
                else            dec.illegal = 1'b1;
            end
            default:           dec.illegal = 1'b1;
        endcase
        if (inst[1:0] != 2'b11) dec.illegal = 1'b1;
        if (dec.illegal) begin
            dec.gpr_ren = 2'b00;
            imm32       = '0;
        end
        dec.imm       = {XLEN{imm32[31]}};
        dec.imm[31:0] = imm32;
        dec.ebreak    = (inst == 32'h0010_0073);
    end

    always_comb begin
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (bus.flush) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {bus.in_pc, bus.in_inst};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + 1'b1;
                out_d       = dec;
                out_valid_d = 1'b1;
            end else if (bus.out_ready) begin
                out_valid_d = 1'b0;
            end
            count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
        mem_q <= mem_d;
    end

    assign bus.in_ready    = in_ready;
    assign bus.count       = count_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = out_q.pc;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_op      = out_q.op;
    assign bus.out_rd      = out_q.rd;
    assign bus.out_func3   = out_q.func3;
    assign bus.out_func7   = out_q.func7;
    assign bus.out_raddr1  = out_q.raddr1;
    assign bus.out_raddr2  = out_q.raddr2;
    assign bus.out_gpr_ren = out_q.gpr_ren;
    assign bus.out_illegal = out_q.illegal;
    assign bus.out_ebreak  = out_q.ebreak;
endmodule

// File: tb/tb_ysyx_23060201_idu_stage.sv
// tb/tb_ysyx_23060201_idu_stage.sv - bench for the decode stage, 64- and 32-bit instances in lockstep
module tb_ysyx_23060201_idu_stage;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  f3;
        logic [1:0]  ren;
        logic        ill;
        logic        eb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    int          n_asserts = 0;
    int          n_fail = 0;

    ent_t        mq[$];
    bit          mov;
    ent_t        mout;
    logic [6:0]  op_tab [14] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17,
                                 7'h6F, 7'h67, 7'h73, 7'h1B, 7'h3B, 7'h7F, 7'h5B};

    always #5 clk = ~clk;

    ysyx_23060201_idu_stage_if #(.XLEN(64), .DEPTH(DEPTH)) b64 ();
    ysyx_23060201_idu_stage_if #(.XLEN(32), .DEPTH(DEPTH)) b32 ();

    assign b64.flush = flush;     assign b32.flush = flush;
    assign b64.in_valid = in_valid;  assign b32.in_valid = in_valid;
    assign b64.in_inst = in_inst;   assign b32.in_inst = in_inst;
    assign b64.in_pc = in_pc;     assign b32.in_pc = in_pc[31:0];
    assign b64.out_ready = out_ready; assign b32.out_ready = out_ready;

    ysyx_23060201_idu_stage #(.XLEN(64), .DEPTH(DEPTH)) u_dut64 (.clk(clk), .rst(rst), .bus(b64));
    ysyx_23060201_idu_stage #(.XLEN(32), .DEPTH(DEPTH)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] inst, input bit is64);
        exp_t   e;
        longint imm;
        e = '0;
        imm = 0;
        e.f3 = inst[14:12];
        case (inst[6:0])
            7'h33:               e.ren = 2'd3;
            7'h13, 7'h03, 7'h67: begin imm = $signed(inst[31:20]); e.ren = 2'd1; end
            7'h73:               imm = $signed(inst[31:20]);
            7'h23: begin imm = $signed({inst[31:25], inst[11:7]}); e.ren = 2'd3; end
            7'h63: begin imm = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}); e.ren = 2'd3; end
            7'h37, 7'h17: begin imm = $signed({inst[31:12], 12'h000}); e.f3 = 3'd0; end
            7'h6F: imm = $signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
            7'h1B: if (is64) begin imm = $signed(inst[31:20]); e.ren = 2'd1; end else e.ill = 1'b1;
            7'h3B: if (is64) e.ren = 2'd3; else e.ill = 1'b1;
            default: e.ill = 1'b1;
        endcase
        if (e.ill) e.ren = 2'd0;
        e.imm = is64 ? imm : {32'h0, imm[31:0]};
        e.eb  = (inst == 32'h0010_0073);
        return e;
    endfunction

    task automatic chk_dut(input string s, input bit is64, input logic rdy, input logic [63:0] cnt,
                           input logic ov, input logic [63:0] pc, input logic [63:0] imm,
                           input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [1:0] ren, input logic ill, input logic eb);
        exp_t e;
        chk({s, "_in_ready"}, rdy, mq.size() < DEPTH);
        chk({s, "_count"}, cnt, mq.size());
        chk({s, "_out_valid"}, ov, mov);
        if (mov) begin
            e = ref_dec(mout.inst, is64);
            chk({s, "_pc"}, pc, is64 ? mout.pc : {32'h0, mout.pc[31:0]});
            if (!e.ill) chk({s, "_imm"}, imm, e.imm);
            chk({s, "_op"}, op, mout.inst[6:0]);
            chk({s, "_rd"}, rd, mout.inst[11:7]);
            chk({s, "_func3"}, f3, e.f3);
            chk({s, "_func7"}, f7, mout.inst[31:25]);
            chk({s, "_raddr1"}, r1, mout.inst[19:15]);
            chk({s, "_raddr2"}, r2, mout.inst[24:20]);
            chk({s, "_gpr_ren"}, ren, e.ren);
            chk({s, "_illegal"}, ill, e.ill);
            chk({s, "_ebreak"}, eb, e.eb);
        end
    endtask

    task automatic model_step();
        bit push, pop;
        if (rst || flush) begin
            mq.delete();
            mov = 1'b0;
        end else begin
            push = in_valid && (mq.size() < DEPTH);
            pop  = (mq.size() > 0) && (!mov || out_ready);
            if (pop) begin
                mout = mq.pop_front();
                mov  = 1'b1;
            end else if (out_ready) begin
                mov = 1'b0;
            end
            if (push) mq.push_back({in_pc, in_inst});
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk_dut("d64", 1'b1, b64.in_ready, 64'(b64.count), b64.out_valid, b64.out_pc, b64.out_imm,
                b64.out_op, b64.out_rd, b64.out_func3, b64.out_func7, b64.out_raddr1, b64.out_raddr2,
                b64.out_gpr_ren, b64.out_illegal, b64.out_ebreak);
        chk_dut("d32", 1'b0, b32.in_ready, 64'(b32.count), b32.out_valid, {32'h0, b32.out_pc},
                {32'h0, b32.out_imm}, b32.out_op, b32.out_rd, b32.out_func3, b32.out_func7,
                b32.out_raddr1, b32.out_raddr2, b32.out_gpr_ren, b32.out_illegal, b32.out_ebreak);
    endtask

    task automatic send(input logic [31:0] inst, input logic [63:0] pc);
        in_valid = 1'b1; in_inst = inst; in_pc = pc; out_ready = 1'b1;
        cycle();
        chk("latency_edge1", b64.out_valid, 1'b0);
        in_valid = 1'b0;
        cycle();
        chk("latency_edge2", b64.out_valid, 1'b1);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        int          k;
        r = $urandom();
        k = $urandom_range(0, 15);
        if (k == 15) return 32'h0010_0073;
        if (k == 14) return r;
        return {r[31:7], op_tab[k]};
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0; in_pc = '0;
        cycle(); cycle();
        chk("rst_count", 64'(b64.count), 0);
        chk("rst_out_valid", b64.out_valid, 0);
        chk("rst_in_ready", b64.in_ready, 1);
        chk("rst_out_pc", b64.out_pc, 0);
        chk("rst_out_imm", b64.out_imm, 0);
        chk("rst_gpr_ren", b64.out_gpr_ren, 0);
        chk("rst_illegal", b64.out_illegal, 0);
        chk("rst_ebreak", b64.out_ebreak, 0);
        rst = 1'b0;

        send(32'hFFF0_0093, 64'h8000_0000_0000_1000);
        chk("addi_imm", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_rd", b64.out_rd, 1);
        chk("addi_ren", b64.out_gpr_ren, 2'b01);
        chk("addi_illegal", b64.out_illegal, 0);
        chk("addi_imm32", b32.out_imm, 32'hFFFF_FFFF);
        cycle();

        send(32'h8000_0137, 64'h1004);
        chk("lui_imm", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui_func3", b64.out_func3, 3'b000);
        chk("lui_ren", b64.out_gpr_ren, 2'b00);
        cycle();

        send(32'h0010_0073, 64'h1008);
        chk("ebreak_flag", b64.out_ebreak, 1);
        chk("ebreak_illegal", b64.out_illegal, 0);
        cycle();
        send(32'h0000_007F, 64'h100C);
        chk("op7f_illegal", b64.out_illegal, 1);
        chk("op7f_ren", b64.out_gpr_ren, 2'b00);
        cycle();
        send(32'h0000_001B, 64'h1010);
        chk("iw_illegal32", b32.out_illegal, 1);
        chk("iw_legal64", b64.out_illegal, 0);
        cycle();

        // back-pressure fill: one in the output register, DEPTH queued, sixth blocked
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_inst = 32'h0000_0013; in_pc = 64'h2000 + 64'(4 * k);
            cycle();
        end
        chk("full_count", 64'(b64.count), 4);
        chk("full_in_ready", b64.in_ready, 0);
        chk("full_head_pc", b64.out_pc, 64'h2000);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            cycle();
            chk("drain_pc", b64.out_pc, 64'h2000 + 64'(4 * k));
        end
        cycle();
        chk("drain_sixth_absent", b64.out_valid, 0);

        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_inst = 32'h0030_8113; in_pc = 64'h3000 + 64'(4 * k);
            cycle();
        end
        chk("preflush_count", 64'(b64.count), 3);
        chk("preflush_valid", b64.out_valid, 1);
        flush = 1'b1; in_pc = 64'h3FF0;
        cycle();
        chk("flush_count", 64'(b64.count), 0);
        chk("flush_valid", b64.out_valid, 0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("flush_no_output", b64.out_valid, 0);
        end

        for (int k = 0; k < 2 * DEPTH + 5; k++) begin
            in_valid = (k < 2 * DEPTH + 3); in_inst = 32'h0041_0193; in_pc = 64'h4000 + 64'(4 * k);
            cycle();
            if (k >= 1 && k <= 2 * DEPTH + 3) begin
                chk("stream_valid", b64.out_valid, 1);
                chk("stream_pc", b64.out_pc, 64'h4000 + 64'(4 * (k - 1)));
            end
        end

        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_inst = 32'h0000_0033; in_pc = 64'h5000 + 64'(4 * k);
            cycle();
        end
        rst = 1'b1; in_valid = 1'b0;
        cycle();
        chk("midrst_count", 64'(b64.count), 0);
        chk("midrst_valid", b64.out_valid, 0);
        chk("midrst_pc", b64.out_pc, 0);
        rst = 1'b0;

        for (int k = 0; k < 400; k++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_inst   = rand_inst();
            in_pc     = {$urandom(), $urandom()};
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
